// File: rtl/cga_vram_arbiter.sv
// ----------------------------------------------------------------------------
// cga_vram_arbiter
//   Shares the single VRAM port between the CGA display fetch path and ISA
//   CPU memory cycles. The display always wins; a CPU request waits in PEND
//   until the sequencer offers a slot (isa_op_enable) that the display does
//   not claim (vram_read). It then gets exactly one ACCESS cycle.
//
// Ports
//   clk, reset_n          pixel clock, async active-low reset
//   isa_op_enable         sequencer marks a CPU-eligible slot
//   vram_read             display fetch owns RAM this cycle
//   disp_a                display fetch address
//   bus_a, bus_d          ISA offset within the window / write data
//   bus_memr_l/memw_l     ISA memory read / write strobes (active low, async)
//   ram_d                 VRAM read data
//   ram_a, ram_we_l, ram_wd  VRAM address / write enable (low) / write data
//   cpu_rd_data           data of the last completed CPU read
//   bus_rdy               ISA ready (held low while a request is in flight)
//   busy                  CPU request pending or active
// ----------------------------------------------------------------------------
module cga_vram_arbiter #(
   parameter bit         USE_BUS_WAIT = 1'b1,
   parameter logic [3:0] VRAM_BASE    = 4'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        isa_op_enable,
   input  logic        vram_read,
   input  logic [18:0] disp_a,
   input  logic [14:0] bus_a,
   input  logic        bus_memr_l,
   input  logic        bus_memw_l,
   input  logic [7:0]  bus_d,
   input  logic [7:0]  ram_d,
   output logic [18:0] ram_a,
   output logic        ram_we_l,
   output logic [7:0]  ram_wd,
   output logic [7:0]  cpu_rd_data,
   output logic        bus_rdy,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, PEND, ACCESS, DONE} state_t;

   state_t      state, state_nxt;

   // [0] first sync flop, [1] synced strobe, [2] synced strobe last cycle
   logic [2:0]  memr_sync, memw_sync;
   // fill[1] marks that [1] holds a real sample rather than the reset value
   logic [1:0]  fill;
   // An edge is only honoured once the synced strobe has been seen inactive,
   // so a strobe already low at reset release cannot fake a request.
   logic        memr_arm, memw_arm;
   logic        memr_edge, memw_edge, req_edge;

   logic [14:0] addr_q;
   logic [7:0]  data_q;
   logic        is_wr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         memr_sync <= 3'b111;
         memw_sync <= 3'b111;
         fill      <= 2'b00;
         memr_arm  <= 1'b0;
         memw_arm  <= 1'b0;
      end else begin
         memr_sync <= {memr_sync[1:0], bus_memr_l};
         memw_sync <= {memw_sync[1:0], bus_memw_l};
         fill      <= {fill[0], 1'b1};
         memr_arm  <= memr_arm | (fill[1] & memr_sync[1]);
         memw_arm  <= memw_arm | (fill[1] & memw_sync[1]);
      end
   end

   assign memr_edge = memr_arm & ~memr_sync[1] & memr_sync[2];
   assign memw_edge = memw_arm & ~memw_sync[1] & memw_sync[2];
   assign req_edge  = memr_edge | memw_edge;

   // Request latches only load from IDLE, so edges seen later are dropped.
   // A simultaneous read+write edge is taken as a write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         data_q  <= '0;
         is_wr_q <= 1'b0;
      end else if (state == IDLE && req_edge) begin
         addr_q  <= bus_a;
         data_q  <= bus_d;
         is_wr_q <= memw_edge;
      end
   end

   // ram_d belongs to the CPU address only during ACCESS, so it is sampled
   // on the ACCESS->DONE edge and is visible from the first DONE cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cpu_rd_data <= 8'h00;
      else if (state == ACCESS && !is_wr_q)
         cpu_rd_data <= ram_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ram_a     = disp_a;
      ram_we_l  = 1'b1;
      ram_wd    = data_q;
      busy      = 1'b0;
      case (state)
         IDLE:   if (req_edge) state_nxt = PEND;
         PEND: begin
            busy = 1'b1;
            // display fetch has priority over a CPU-eligible slot
            if (isa_op_enable && !vram_read) state_nxt = ACCESS;
         end
         ACCESS: begin
            busy      = 1'b1;
            ram_a     = {VRAM_BASE, addr_q};
            ram_we_l  = ~is_wr_q;
            state_nxt = DONE;
         end
         DONE:   if (memr_sync[1] && memw_sync[1]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      bus_rdy = USE_BUS_WAIT ? ~busy : 1'b1;
   end

endmodule

// File: doc/cga_vram_arbiter.md
CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
Parameters and ports shared by the CGA display fetch path and ISA CPU memory cycles on the single VRAM port.
REQ-001 Parameters (name, default, meaning), one per line:
- USE_BUS_WAIT, 1, 1 = drive bus_rdy low until the CPU access completes; 0 = tie bus_rdy to 1.
- VRAM_BASE, 4'h0, value driven on ram_a[18:15] for CPU accesses.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock.
- reset_n, in, 1, asynchronous active-low reset.
- isa_op_enable, in, 1, sequencer marks a CPU-eligible slot.
- vram_read, in, 1, display fetch owns RAM this cycle.
- disp_a, in, 19, display fetch address.
- bus_a, in, 15, ISA memory offset within the window.
- bus_memr_l, in, 1, ISA memory read strobe (active low).
- bus_memw_l, in, 1, ISA memory write strobe (active low).
- bus_d, in, 8, ISA write data.
- ram_d, in, 8, VRAM read data.
- ram_a, out, 19, VRAM address.
- ram_we_l, out, 1, VRAM write enable (active low).
- ram_wd, out, 8, VRAM write data.
- cpu_rd_data, out, 8, latched CPU read data.
- bus_rdy, out, 1, ISA ready.
- busy, out, 1, CPU request pending or active.

Function
REQ-003 bus_memr_l and bus_memw_l SHALL each pass through a 2-flop synchronizer; a request edge is synced strobe active now AND inactive the previous cycle.
REQ-004 The FSM SHALL have exactly four states: IDLE, PEND, ACCESS, DONE.
REQ-005 IDLE->PEND on a request edge, capturing in the same cycle:
- bus_a into the address latch.
- bus_d into the data latch.
- type: write if the memw edge is present, else read.
REQ-006 A simultaneous memr and memw edge SHALL be treated as a write.
REQ-007 Request edges arriving in PEND, ACCESS or DONE SHALL be ignored, with no state or latch change.
REQ-008 PEND->ACCESS on the first cycle with isa_op_enable=1 and vram_read=0; otherwise remain in PEND indefinitely.
REQ-009 ACCESS SHALL last exactly one cycle, then go to DONE.
REQ-010 In ACCESS: ram_a = {VRAM_BASE, latched address}; ram_wd = latched data; ram_we_l = 0 for a write, 1 for a read.
REQ-011 In every state other than ACCESS: ram_a = disp_a; ram_we_l = 1; ram_wd = latched data.
REQ-012 Display priority: if vram_read=1 in the same cycle the FSM would enter ACCESS, the entry SHALL be deferred; the display is never stalled.
REQ-013 In the first DONE cycle of a read, ram_d SHALL be registered into cpu_rd_data; cpu_rd_data SHALL hold its value until the next read completes.
REQ-014 DONE->IDLE when both synced strobes are inactive, which may be the first DONE cycle.
REQ-015 The latched request SHALL complete even if the strobe is released while in PEND: a write is committed and a read still updates cpu_rd_data.
REQ-016 bus_rdy with USE_BUS_WAIT=1: 0 from the cycle after a request edge through the last PEND/ACCESS cycle; 1 in DONE and IDLE.
REQ-017 bus_rdy with USE_BUS_WAIT=0: constant 1, while REQ-005..REQ-015 still apply.
REQ-018 busy SHALL be 1 in PEND and ACCESS, and 0 otherwise.
REQ-019 Worst-case latency is bounded by the sequencer slot period; the block SHALL NOT add any timeout.

Reset
REQ-020 reset_n=0 SHALL asynchronously force:
- state = IDLE.
- synchronizer flops = 1 (inactive).
- address, data and type latches = 0.
- cpu_rd_data = 8'h00; busy = 0.
- bus_rdy = 1.
- ram_we_l = 1; ram_a = disp_a.
REQ-021 Reset asserted mid-ACCESS SHALL abort the write with ram_we_l=1 immediately; the request is lost.
REQ-022 After reset release, a strobe already low SHALL NOT produce a request edge until it goes high and low again.

Verification
REQ-023 Write: bus_a=15'h0123, bus_d=8'hA5, memw_l low, slot 6 cycles later -> one cycle with ram_a=19'h00123, ram_we_l=0, ram_wd=8'hA5; bus_rdy low until then.
REQ-024 Read: VRAM[0x7FFF]=8'h3C, memr_l low -> cpu_rd_data=8'h3C in DONE; bus_rdy rises in the same cycle.
REQ-025 Conflict: isa_op_enable=1 with vram_read=1 for 3 cycles, then vram_read=0 -> ACCESS only on the 4th cycle; ram_a=disp_a throughout the first 3.
REQ-026 USE_BUS_WAIT=0: memw pulse of 2 cycles released before the slot -> write still committed; bus_rdy stays 1.
REQ-027 Second memw edge while in PEND -> ignored; exactly one write occurs, carrying the first request's data.
REQ-028 reset_n low during ACCESS -> ram_we_l=1, state IDLE, cpu_rd_data=8'h00, bus_rdy=1 before the next clk edge.
